// File: rtl/irq_dispatch_pkg.sv
// Shared types and constants for the interrupt dispatcher: FSM states,
// upstream bus codes and vector geometry.
package irq_dispatch_pkg;
  localparam int VEC_W    = 6;
  localparam int CHAN_W   = 4;
  localparam int MAX_CHAN = 8;

  typedef enum logic [1:0] {IDLE, QUAL, REQ, SERVICE} state_t;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    BUS_A = 2'b01,
    BUS_B = 2'b10,
    BUS_C = 2'b11
  } bus_code_t;

  // Fixed priority: pa over pb over pc.
  function automatic bus_code_t bus_encode(input logic pa, input logic pb, input logic pc);
    if (pa) return BUS_A;
    if (pb) return BUS_B;
    if (pc) return BUS_C;
    return NONE;
  endfunction
endpackage

// File: rtl/irq_dispatch_if.sv
// Upstream request flags plus the CPU-side interrupt handshake of the dispatcher.
interface irq_dispatch_if;
  import irq_dispatch_pkg::*;

  logic              pa;
  logic              pb;
  logic              pc;
  logic [CHAN_W-1:0] chan;
  logic              irq_req;
  logic [VEC_W-1:0]  irq_vec;
  logic              irq_ack;
  logic              eoi;
  logic              in_service;
  logic [7:0]        timeout_cnt;
  logic              err_chan;

  modport master (
    output pa, pb, pc, chan, irq_ack, eoi,
    input  irq_req, irq_vec, in_service, timeout_cnt, err_chan
  );

  modport slave (
    input  pa, pb, pc, chan, irq_ack, eoi,
    output irq_req, irq_vec, in_service, timeout_cnt, err_chan
  );
endinterface

// File: rtl/irq_qualifier.sv
// Registers the glitch-prone upstream request every cycle, rejects bad channel
// codes and counts consecutive identical samples while the FSM is qualifying.
module irq_qualifier
  import irq_dispatch_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pa,
  input  logic              pb,
  input  logic              pc,
  input  logic [CHAN_W-1:0] chan,
  input  logic              start,
  input  logic              track,
  output logic [VEC_W-1:0]  code,
  output logic              code_valid,
  output logic              hold,
  output logic              done,
  output logic              err_chan
);
  bus_code_t        bus_code;
  logic             range_err;
  logic [VEC_W-1:0] code_in;
  logic [VEC_W-1:0] sample_q;
  logic [VEC_W-1:0] cand_q;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_next;

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    bus_code  = bus_encode(pa, pb, pc);
    range_err = (bus_code != NONE) && (chan > CHAN_W'(MAX_CHAN));
    code_in   = '0;
    if (bus_code != NONE && !range_err) code_in = {bus_code, chan};
  end

  assign code       = sample_q;
  assign code_valid = bus_code_t'(sample_q[VEC_W-1 -: 2]) != NONE;
  // The candidate is captured on entry to qualification, so it always equals the previous sample.
  assign hold       = (sample_q == cand_q);

  always_comb begin
    cnt_next = '0;
    if (start && code_valid) cnt_next = 4'd1;
    else if (track && hold)  cnt_next = cnt_q + 4'd1;
  end

  assign done = (cnt_next == 4'(STABLE_CYCLES));

  // NOTE: state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      err_chan <= 1'b0;
    end else begin
      sample_q <= code_in;
      cnt_q    <= cnt_next;
      if (start)     cand_q   <= sample_q;
      if (range_err) err_chan <= 1'b1;
    end
  end
endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: qualifies a stable upstream request, raises irq_req
// with a frozen vector, and tracks ack / end-of-interrupt / timeout.
module irq_dispatch
  import irq_dispatch_pkg::*;
#(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           rst_n,
  irq_dispatch_if.slave bus
);
  state_t           state;
  logic [VEC_W-1:0] code;
  logic             code_valid;
  logic             hold;
  logic             done;
  logic             err_chan;
  logic             irq_req_q;
  logic             in_service_q;
  logic [VEC_W-1:0] vec_q;
  logic [7:0]       wait_cnt;
  logic [7:0]       timeout_q;

  irq_qualifier #(.STABLE_CYCLES(STABLE_CYCLES)) u_qualifier (
    .clk        (clk),
    .rst_n      (rst_n),
    .pa         (bus.pa),
    .pb         (bus.pb),
    .pc         (bus.pc),
    .chan       (bus.chan),
    .start      (state == IDLE),
    .track      (state == QUAL),
    .code       (code),
    .code_valid (code_valid),
    .hold       (hold),
    .done       (done),
    .err_chan   (err_chan)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      irq_req_q    <= 1'b0;
      in_service_q <= 1'b0;
      vec_q        <= '0;
      wait_cnt     <= '0;
      timeout_q    <= '0;
    end else begin
      case (state)
        IDLE, QUAL: begin
          if (done) begin
            state     <= REQ;
            vec_q     <= code;
            irq_req_q <= 1'b1;
            wait_cnt  <= '0;
          end else if (state == IDLE && code_valid) begin
            state <= QUAL;
          end else if (state == QUAL && !hold) begin
            state <= IDLE;
          end
        end
        REQ: begin
          // Ack is checked first so it wins over a timeout in the same cycle.
          if (bus.irq_ack) begin
            state        <= SERVICE;
            irq_req_q    <= 1'b0;
            in_service_q <= 1'b1;
          end else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            irq_req_q <= 1'b0;
            if (timeout_q != 8'hFF) timeout_q <= timeout_q + 8'd1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        SERVICE: begin
          if (bus.eoi) begin
            state        <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.irq_req     = irq_req_q;
  assign bus.irq_vec     = vec_q;
  assign bus.in_service  = in_service_q;
  assign bus.timeout_cnt = timeout_q;
  assign bus.err_chan    = err_chan;
endmodule

// File: tb/tb_irq_dispatch.sv
// Self-checking bench for irq_dispatch: vector table, directed corner sequences,
// and randomized traffic against a run-length reference model on two parameter sets.
module tb_irq_dispatch;
  import irq_dispatch_pkg::*;

  localparam int S0 = 2, T0 = 255;
  localparam int S1 = 3, T1 = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irq_dispatch_if if0();
  irq_dispatch_if if1();

  irq_dispatch #(.STABLE_CYCLES(S0), .TIMEOUT_CYCLES(T0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  irq_dispatch #(.STABLE_CYCLES(S1), .TIMEOUT_CYCLES(T1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a request fires once S consecutive identical valid samples
  // have been seen while free; a changed sample breaks the run and is discarded.
  typedef struct packed {
    logic             req;
    logic             svc;
    logic             err;
    logic [VEC_W-1:0] vec;
    logic [VEC_W-1:0] smp;
    logic [VEC_W-1:0] last;
    int               run;
    int               age;
    int               tmo;
  } model_t;

  model_t m0, m1;

  function automatic model_t model_step(model_t m, logic rst, logic pa, logic pb, logic pc,
                                        logic [3:0] chan, logic ack, logic eoi, int s_cyc, int t_cyc);
    model_t     n = m;
    logic [1:0] bus;
    if (!rst) begin
      n = '0;
      return n;
    end
    if (m.req) begin
      if (ack) begin
        n.req = 1'b0;
        n.svc = 1'b1;
      end else begin
        n.age = m.age + 1;
        if (n.age == t_cyc) begin
          n.req = 1'b0;
          if (m.tmo < 255) n.tmo = m.tmo + 1;
        end
      end
    end else if (m.svc) begin
      if (eoi) n.svc = 1'b0;
    end else begin
      if (m.run == 0) n.run = (m.smp != 0) ? 1 : 0;
      else            n.run = (m.smp == m.last) ? m.run + 1 : 0;
      n.last = m.smp;
      if (n.run == s_cyc) begin
        n.req = 1'b1;
        n.vec = m.smp;
        n.age = 0;
        n.run = 0;
      end
    end
    bus = pa ? 2'd1 : pb ? 2'd2 : pc ? 2'd3 : 2'd0;
    if (bus != 2'd0 && chan > 4'd8) begin
      n.err = 1'b1;
      n.smp = '0;
    end else begin
      n.smp = (bus == 2'd0) ? '0 : {bus, chan};
    end
    return n;
  endfunction

  function automatic logic [16:0] model_out(model_t m);
    return {m.req, m.vec, m.svc, 8'(m.tmo), m.err};
  endfunction

  always @(posedge clk) begin
    m0 <= model_step(m0, rst_n, if0.pa, if0.pb, if0.pc, if0.chan, if0.irq_ack, if0.eoi, S0, T0);
    m1 <= model_step(m1, rst_n, if1.pa, if1.pb, if1.pc, if1.chan, if1.irq_ack, if1.eoi, S1, T1);
  end

  task automatic set_in(input logic pa, input logic pb, input logic pc, input logic [3:0] chan,
                        input logic ack, input logic eoi);
    if0.pa = pa; if0.pb = pb; if0.pc = pc; if0.chan = chan; if0.irq_ack = ack; if0.eoi = eoi;
    if1.pa = pa; if1.pb = pb; if1.pc = pc; if1.chan = chan; if1.irq_ack = ack; if1.eoi = eoi;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 4'd0, 0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic             pa, pb, pc;
    logic [3:0]       chan;
    logic             exp_req;
    logic [VEC_W-1:0] exp_vec;
    logic             exp_err;
  } vec_t;

  vec_t       vecs[9];
  logic       r_pa, r_pb, r_pc;
  logic [3:0] r_chan;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 4'd5,  1'b1, 6'b01_0101, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 4'd3,  1'b1, 6'b01_0011, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 4'd7,  1'b1, 6'b10_0111, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 4'd8,  1'b1, 6'b11_1000, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 4'd12, 1'b0, 6'b00_0000, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 4'd5,  1'b0, 6'b00_0000, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 4'd0,  1'b1, 6'b01_0000, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 4'd9,  1'b0, 6'b00_0000, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 6'b00_0000, 1'b0};

    set_in(0, 0, 0, 4'd0, 0, 0);
    @(negedge clk);
    do_reset();
    check("rst_req", if0.irq_req, 0);
    check("rst_vec", if0.irq_vec, 0);
    check("rst_svc", if0.in_service, 0);
    check("rst_tmo", if0.timeout_cnt, 0);
    check("rst_err", if0.err_chan, 0);
    check("rst_dut1", {if1.irq_req, if1.irq_vec, if1.in_service, if1.timeout_cnt, if1.err_chan}, 0);

    // Vector table: hold one input pattern, check latency edge, vector, error flag and ack.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      set_in(vecs[i].pa, vecs[i].pb, vecs[i].pc, vecs[i].chan, 0, 0);
      tick(); tick();
      check($sformatf("vec%0d_early", i), if0.irq_req, 0);
      tick();
      check($sformatf("vec%0d_req", i), if0.irq_req, vecs[i].exp_req);
      check($sformatf("vec%0d_vec", i), if0.irq_vec, vecs[i].exp_vec);
      check($sformatf("vec%0d_err", i), if0.err_chan, vecs[i].exp_err);
      set_in(0, 0, 0, 4'd0, 1, 0);
      tick();
      check($sformatf("vec%0d_ack", i), if0.in_service, vecs[i].exp_req);
      set_in(0, 0, 0, 4'd0, 0, 1);
      tick();
      check($sformatf("vec%0d_eoi", i), if0.in_service, 0);
    end

    // Full transaction, frozen vector, ignored eoi/ack, and requalification after eoi.
    do_reset();
    set_in(1, 0, 0, 4'd5, 0, 0);
    tick(); check("a_c1", if0.irq_req, 0);
    tick(); check("a_c2", if0.irq_req, 0);
    tick(); check("a_c3_req", if0.irq_req, 1);
    check("a_c3_vec", if0.irq_vec, 6'b01_0101);
    set_in(0, 1, 0, 4'd7, 0, 1);
    tick();
    check("a_frozen_vec", if0.irq_vec, 6'b01_0101);
    check("a_eoi_in_req", {if0.irq_req, if0.in_service}, 2'b10);
    set_in(0, 0, 0, 4'd0, 0, 0);
    tick();
    check("a_drop_vec", {if0.irq_req, if0.irq_vec}, 7'b1_01_0101);
    set_in(1, 0, 0, 4'd5, 1, 0);
    tick();
    check("a_ack", {if0.irq_req, if0.in_service}, 2'b01);
    tick();
    check("a_ack_in_svc", {if0.irq_req, if0.in_service}, 2'b01);
    set_in(1, 0, 0, 4'd5, 0, 1);
    tick();
    check("a_eoi", {if0.irq_req, if0.in_service}, 2'b00);
    set_in(1, 0, 0, 4'd5, 0, 0);
    tick(); check("a_requal_early", if0.irq_req, 0);
    tick(); check("a_requal", if0.irq_req, 1);

    // Channel toggling never qualifies; a steady channel then does.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, 1, (i % 2 == 1) ? 4'd4 : 4'd2, 0, 0);
      tick();
      check($sformatf("b_toggle%0d", i), if0.irq_req, 0);
    end
    for (int i = 0; i < 6 && !if0.irq_req; i++) tick();
    check("b_settle_req", if0.irq_req, 1);
    check("b_settle_vec", if0.irq_vec, 6'b11_0100);

    // Timeout after exactly TIMEOUT_CYCLES request cycles; late ack ignored.
    do_reset();
    set_in(1, 0, 0, 4'd1, 0, 0);
    tick(); tick(); tick();
    check("c_req", if0.irq_req, 1);
    set_in(0, 0, 0, 4'd0, 0, 0);
    for (int i = 0; i < T0 - 1; i++) tick();
    check("c_last_cycle", {if0.irq_req, if0.timeout_cnt}, {1'b1, 8'd0});
    tick();
    check("c_timeout", {if0.irq_req, if0.timeout_cnt}, {1'b0, 8'd1});
    set_in(0, 0, 0, 4'd0, 1, 0);
    tick();
    check("c_late_ack", if0.in_service, 0);

    // Channel error is sticky and blocks the request; reset mid-service clears everything.
    set_in(0, 1, 0, 4'd12, 0, 0);
    tick();
    check("d_err_set", if0.err_chan, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("d_no_req%0d", i), if0.irq_req, 0);
    end
    set_in(0, 0, 0, 4'd0, 0, 0);
    tick();
    check("d_err_sticky", if0.err_chan, 1);
    set_in(1, 0, 0, 4'd5, 0, 0);
    tick(); tick(); tick();
    set_in(1, 0, 0, 4'd5, 1, 0);
    tick();
    check("d_in_service", if0.in_service, 1);
    rst_n = 1'b0;
    set_in(0, 0, 0, 4'd0, 0, 0);
    tick();
    rst_n = 1'b1;
    check("d_rst_outputs", {if0.irq_req, if0.irq_vec, if0.in_service, if0.timeout_cnt, if0.err_chan}, 0);

    // Ack presented in the final request cycle wins over the timeout.
    do_reset();
    set_in(1, 0, 0, 4'd1, 0, 0);
    tick(); tick(); tick();
    set_in(0, 0, 0, 4'd0, 0, 0);
    for (int i = 0; i < T0 - 1; i++) tick();
    set_in(0, 0, 0, 4'd0, 1, 0);
    tick();
    check("e_ack_wins", {if0.irq_req, if0.in_service, if0.timeout_cnt}, {2'b01, 8'd0});
    set_in(0, 0, 0, 4'd0, 0, 1);
    tick();

    // Short-timeout instance saturates its timeout counter.
    do_reset();
    set_in(1, 0, 0, 4'd2, 0, 0);
    for (int i = 0; i < 2400; i++) tick();
    check("f_tmo_saturate", if1.timeout_cnt, 8'd255);

    // Randomized traffic against the reference model on both instances.
    do_reset();
    r_pa = 0; r_pb = 0; r_pc = 0; r_chan = 4'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 5) == 0) begin
        r_pa = ($urandom_range(0, 3) == 0);
        r_pb = ($urandom_range(0, 3) == 0);
        r_pc = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 5) == 0) r_chan = 4'($urandom_range(0, 10));
      rst_n = ($urandom_range(0, 399) != 0);
      set_in(r_pa, r_pb, r_pc, r_chan, $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0);
      tick();
      check("rand0", {if0.irq_req, if0.irq_vec, if0.in_service, if0.timeout_cnt, if0.err_chan}, model_out(m0));
      check("rand1", {if1.irq_req, if1.irq_vec, if1.in_service, if1.timeout_cnt, if1.err_chan}, model_out(m1));
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_dispatch.md
IRQ_DISPATCH -- requirements
Module: irq_dispatch

Interface
REQ-001 Parameter STABLE_CYCLES, default 2, SHALL be the consecutive identical samples required to qualify a request (range 1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL be the cycles irq_req may wait for irq_ack before withdrawal (range 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 pa, pb, pc  input  1 each  SHALL be the bus-request flags from the upstream 27-channel priority controller (combinational, glitch-prone).
REQ-006 chan  input  4  SHALL be the encoded winning channel (0..8) from the upstream controller.
REQ-007 irq_req  output  1  SHALL be the interrupt request to the CPU.
REQ-008 irq_vec  output  6  SHALL be {bus_code[1:0], chan[3:0]} of the latched request.
REQ-009 irq_ack  input  1  SHALL be the CPU acknowledge.
REQ-010 eoi  input  1  SHALL be the CPU end-of-interrupt pulse.
REQ-011 in_service  output  1  SHALL be high between accepted ack and eoi.
REQ-012 timeout_cnt  output  8  SHALL count withdrawn (unacknowledged) requests, saturating at 255.
REQ-013 err_chan  output  1  SHALL be a sticky flag for an out-of-range channel code.

Function
REQ-014 bus_code SHALL be 2'b01 if pa, else 2'b10 if pb, else 2'b11 if pc, else 2'b00 (no request); pa highest priority.
REQ-015 Sampled code SHALL be {bus_code, chan} registered every cycle; a code with bus_code=00 SHALL be "none".
REQ-016 chan > 8 with bus_code != 00 SHALL set err_chan and SHALL be treated as "none" for that sample.
REQ-017 FSM states: IDLE, QUAL, REQ, SERVICE.
REQ-018 IDLE -> QUAL when sampled code is not "none"; qualifier counter loads 1.
REQ-019 QUAL: counter increments while sampled code equals previous; any change (including "none") SHALL return to IDLE; counter reaching STABLE_CYCLES SHALL latch irq_vec and go to REQ.
REQ-020 REQ: irq_req=1 from the first REQ cycle; irq_vec SHALL stay frozen even if inputs change or drop.
REQ-021 REQ + irq_ack -> SERVICE next cycle, irq_req=0, in_service=1.
REQ-022 REQ: wait counter SHALL count cycles; reaching TIMEOUT_CYCLES without ack -> IDLE, irq_req=0, timeout_cnt+1 (saturating).
REQ-023 irq_ack and timeout in the same cycle: ack SHALL win; timeout_cnt unchanged.
REQ-024 SERVICE + eoi -> IDLE, in_service=0; new qualification SHALL start no earlier than the cycle after.
REQ-025 irq_ack outside REQ and eoi outside SERVICE SHALL be ignored without side effect.
REQ-026 Latency: stable request present at cycle 0 -> irq_req high at cycle STABLE_CYCLES+1 (input register + qualification).

Reset
REQ-027 rst_n low at a clock edge SHALL force IDLE, irq_req=0, irq_vec=0, in_service=0, timeout_cnt=0, err_chan=0, all counters and sample registers 0.
REQ-028 Reset in any state, including mid-REQ or mid-SERVICE, SHALL abandon the transaction without counting a timeout.

Structure
REQ-029 Package irq_dispatch_pkg SHALL hold the state enum, bus_code constants (NONE, BUS_A, BUS_B, BUS_C), VEC_W=6 and MAX_CHAN=8.
REQ-030 Sub-module irq_qualifier SHALL implement the sample register, range check and stability counter (REQ-015, -016, -019); the FSM and counters SHALL reside in irq_dispatch.

Verification
REQ-031 pa=1, chan=5 held; STABLE_CYCLES=2 -> irq_req=1 at cycle 3 with irq_vec=6'b01_0101; ack -> in_service=1; eoi -> IDLE.
REQ-032 pa,pb both 1, chan=3 -> irq_vec=6'b01_0011; pb alone, chan=7 -> 6'b10_0111.
REQ-033 chan toggles 2->4 each cycle with pc=1 -> irq_req never rises; then steady chan=4 -> irq_vec=6'b11_0100.
REQ-034 No ack for 255 cycles in REQ -> irq_req drops, timeout_cnt=1; ack on exactly the 255th cycle -> SERVICE, timeout_cnt=0.
REQ-035 pb=1, chan=12 -> err_chan=1 sticky, irq_req stays 0; rst_n low one cycle mid-SERVICE -> all outputs 0 next cycle.
